// File: rtl/memory_arbiter.sv
// memory_arbiter: two-requester (instruction fetch / data) arbiter onto one
// shared memory port. One transaction in flight at a time; a conflict goes
// to whichever side was not served last. Every Mem_* output is registered.
module memory_arbiter #(
   parameter int ADDR_WIDTH = 30
) (
   input  logic                  clock,
   input  logic                  reset,
   // instruction fetch side
   input  logic                  I_Read,
   input  logic [ADDR_WIDTH-1:0] I_Address,
   output logic [31:0]           I_DataOut,
   output logic                  I_Ready,
   // data side
   input  logic                  D_Read,
   input  logic                  D_Write,
   input  logic [3:0]            D_ByteEn,
   input  logic [ADDR_WIDTH-1:0] D_Address,
   input  logic [31:0]           D_DataIn,
   output logic [31:0]           D_DataOut,
   output logic                  D_Ready,
   // shared memory side
   output logic                  Mem_Read,
   output logic                  Mem_Write,
   output logic [ADDR_WIDTH-1:0] Mem_Address,
   output logic [31:0]           Mem_WriteData,
   output logic [3:0]            Mem_ByteEn,
   input  logic [31:0]           Mem_ReadData,
   input  logic                  Mem_Ack
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT_I = 3'd1,
      GRANT_D = 3'd2,
      RESP_I  = 3'd3,
      RESP_D  = 3'd4
   } state_t;

   state_t state, state_nx;

   // 1 = data side was served last; reset to instruction so data wins the
   // first conflict.
   logic last_d;

   logic i_req, d_req;
   logic start_i, start_d;
   logic ack_i, ack_d;

   logic                  mem_read_r, mem_write_r;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic [31:0]           mem_wdata_r;
   logic [3:0]            mem_be_r;
   logic [31:0]           i_data_r, d_data_r;

   assign i_req = I_Read;
   assign d_req = D_Read | D_Write;

   // Acks only count while a grant is outstanding; strays elsewhere are dropped.
   assign ack_i = (state == GRANT_I) && Mem_Ack;
   assign ack_d = (state == GRANT_D) && Mem_Ack;

   // Next-state decode and arbitration.
   always_comb begin
      state_nx = state;
      start_i  = 1'b0;
      start_d  = 1'b0;
      case (state)
         IDLE: begin
            if (i_req && d_req) begin
               // Alternate on conflict: grant the side not served last.
               if (last_d) begin
                  start_i  = 1'b1;
                  state_nx = GRANT_I;
               end else begin
                  start_d  = 1'b1;
                  state_nx = GRANT_D;
               end
            end else if (d_req) begin
               start_d  = 1'b1;
               state_nx = GRANT_D;
            end else if (i_req) begin
               start_i  = 1'b1;
               state_nx = GRANT_I;
            end
         end
         GRANT_I: if (Mem_Ack) state_nx = RESP_I;
         GRANT_D: if (Mem_Ack) state_nx = RESP_D;
         // The Ready cycle is its own state, so IDLE never overlaps a Ready
         // and a requester dropping its request right after Ready is not
         // re-granted.
         RESP_I:  state_nx = IDLE;
         RESP_D:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register and last-served flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         last_d <= 1'b0;
      end else begin
         state <= state_nx;
         if (start_i) last_d <= 1'b0;
         if (start_d) last_d <= 1'b1;
      end
   end

   // Memory request registers: loaded on grant, held stable for the whole
   // grant regardless of what the requester does, strobes dropped on ack.
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         mem_be_r    <= '0;
      end else if (start_i) begin
         mem_read_r  <= 1'b1;
         mem_write_r <= 1'b0;
         mem_addr_r  <= I_Address;
         mem_wdata_r <= '0;
         mem_be_r    <= 4'hF;
      end else if (start_d) begin
         // Read and write together is treated as a write.
         mem_read_r  <= ~D_Write;
         mem_write_r <= D_Write;
         mem_addr_r  <= D_Address;
         mem_wdata_r <= D_DataIn;
         mem_be_r    <= D_ByteEn;
      end else if (ack_i || ack_d) begin
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
      end
   end

   // Read-data capture: only on the acking edge of a read, into the served
   // side's register; writes leave the data side output untouched.
   always_ff @(posedge clock) begin
      if (reset) begin
         i_data_r <= '0;
         d_data_r <= '0;
      end else begin
         if (ack_i && mem_read_r) i_data_r <= Mem_ReadData;
         if (ack_d && mem_read_r) d_data_r <= Mem_ReadData;
      end
   end

   assign I_Ready       = (state == RESP_I);
   assign D_Ready       = (state == RESP_D);
   assign I_DataOut     = i_data_r;
   assign D_DataOut     = d_data_r;
   assign Mem_Read      = mem_read_r;
   assign Mem_Write     = mem_write_r;
   assign Mem_Address   = mem_addr_r;
   assign Mem_WriteData = mem_wdata_r;
   assign Mem_ByteEn    = mem_be_r;

endmodule
